// File: rtl/bldc_commutation_ctrl.sv
// Six-step BLDC commutation sequencer: rotor alignment, a one-index-at-a-time
// speed ramp toward vel[2:0], then steady run with step timing from T_value.
//
// state | meaning
// IDLE  | outputs off, waiting for en with a nonzero target
// ALIGN | phase held at 001 for ALIGN_CYCLES clocks
// RAMP  | stepping, vel_index moves one index per RAMP_STEPS steps
// RUN   | stepping at the target index, running=1
module bldc_commutation_ctrl #(
  parameter int unsigned ALIGN_CYCLES = 50000,
  parameter int unsigned RAMP_STEPS   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  vel,
  input  logic [31:0] T_value,
  output logic [2:0]  vel_index,
  output logic [2:0]  phase_state,
  output logic        step,
  output logic        running
);

  localparam int unsigned SCW = (RAMP_STEPS < 1) ? 1 : $clog2(RAMP_STEPS + 1);
  localparam logic [SCW-1:0] SC_MAX     = SCW'(RAMP_STEPS);
  localparam logic [31:0]    ALIGN_LAST = 32'(ALIGN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RAMP  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [SCW-1:0] scnt_q, scnt_d, scnt_inc;
  logic [2:0]     vi_d, ph_d, vi_toward, ph_next;
  logic           step_d, run_d;
  logic [2:0]     tgt;
  logic           stop;
  logic [31:0]    teff;
  logic           fire;
  logic           unused_vel_hi;

  assign unused_vel_hi = ^vel[7:3];
  assign tgt  = vel[2:0];
  assign stop = !en || (tgt == 3'd0);
  assign teff = (T_value < 32'd2) ? 32'd2 : T_value;
  assign fire = (cnt_q >= teff - 32'd1);
  assign scnt_inc = (scnt_q >= SC_MAX) ? SC_MAX : scnt_q + SCW'(1);

  always_comb begin
    vi_toward = vel_index;
    if (tgt > vel_index)      vi_toward = vel_index + 3'd1;
    else if (tgt < vel_index) vi_toward = vel_index - 3'd1;
  end

  // Commutation order 001,011,010,110,100,101; anything else restarts at 001.
  always_comb begin
    case (phase_state)
      3'b001:  ph_next = 3'b011;
      3'b011:  ph_next = 3'b010;
      3'b010:  ph_next = 3'b110;
      3'b110:  ph_next = 3'b100;
      3'b100:  ph_next = 3'b101;
      default: ph_next = 3'b001;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    vi_d    = vel_index;
    ph_d    = phase_state;
    step_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      scnt_d  = '0;
      vi_d    = 3'd0;
      ph_d    = 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ALIGN;
          ph_d    = 3'b001;
          cnt_d   = '0;
          scnt_d  = '0;
        end
        ALIGN: begin
          if (cnt_q == ALIGN_LAST) begin
            state_d = RAMP;
            ph_d    = 3'b011;
            vi_d    = 3'd1;
            step_d  = 1'b1;
            cnt_d   = '0;
            scnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          if (fire) begin
            cnt_d  = '0;
            ph_d   = ph_next;
            step_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
          if (state_q == RAMP) begin
            if (fire) begin
              if (scnt_inc >= SC_MAX) begin
                scnt_d = '0;
                vi_d   = vi_toward;
              end else begin
                scnt_d = scnt_inc;
              end
            end
            if (vi_d == tgt) state_d = RUN;
          end else begin
            scnt_d = '0;
            if (tgt != vel_index) state_d = RAMP;
          end
        end
      endcase
    end
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      scnt_q      <= '0;
      vel_index   <= 3'd0;
      phase_state <= 3'b000;
      step        <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scnt_q      <= scnt_d;
      vel_index   <= vi_d;
      phase_state <= ph_d;
      step        <= step_d;
      running     <= run_d;
    end
  end

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Bench for bldc_commutation_ctrl: an abstract cycle model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_bldc_commutation_ctrl;

  localparam int AC = 4;
  localparam int RS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  vel = 8'd0;
  logic [31:0] T_value;
  logic [2:0]  vel_index, phase_state;
  logic        step, running;

  logic        use_tbl = 1'b0;
  logic [31:0] t_fixed = 32'd5;
  logic [31:0] tbl [8];

  assign T_value = use_tbl ? tbl[vel_index] : t_fixed;

  bldc_commutation_ctrl #(.ALIGN_CYCLES(AC), .RAMP_STEPS(RS)) dut (
    .clk(clk), .rst(rst_n), .en(en), .vel(vel), .T_value(T_value),
    .vel_index(vel_index), .phase_state(phase_state), .step(step), .running(running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Abstract model: phase as a position in the six-entry table, alignment as
  // clocks remaining, step timing as elapsed clocks against the period.
  int seq [6] = '{1, 3, 2, 6, 4, 5};
  bit m_align = 0, m_spin = 0, m_speed = 0, m_step = 0;
  int m_left = 0, m_pos = -1, m_vi = 0, m_el = 0, m_steps = 0;

  always @(posedge clk or negedge rst_n) begin
    int tgt, per;
    if (!rst_n) begin
      m_align = 0; m_spin = 0; m_speed = 0; m_step = 0;
      m_left = 0; m_pos = -1; m_vi = 0; m_el = 0; m_steps = 0;
    end else begin
      tgt = int'(vel[2:0]);
      m_step = 0;
      if (!en || tgt == 0) begin
        m_align = 0; m_spin = 0; m_speed = 0;
        m_pos = -1; m_vi = 0; m_el = 0; m_steps = 0;
      end else if (!m_align && !m_spin) begin
        m_align = 1; m_left = AC; m_pos = 0;
      end else if (m_align) begin
        m_left--;
        if (m_left == 0) begin
          m_align = 0; m_spin = 1; m_pos = 1; m_vi = 1;
          m_el = 0; m_steps = 0; m_speed = 0; m_step = 1;
        end
      end else begin
        per = use_tbl ? int'(tbl[m_vi]) : int'(t_fixed);
        if (per < 2) per = 2;
        if (m_el + 1 >= per) begin
          m_el = 0; m_pos = (m_pos + 1) % 6; m_step = 1;
        end else begin
          m_el++;
        end
        if (m_speed) begin
          if (m_vi != tgt) begin m_speed = 0; m_steps = 0; end
        end else begin
          if (m_step) begin
            m_steps++;
            if (m_steps >= RS) begin
              m_steps = 0;
              if (tgt > m_vi) m_vi++;
              else if (tgt < m_vi) m_vi--;
            end
          end
          if (m_vi == tgt) m_speed = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_phase", int'(phase_state), (m_pos < 0) ? 0 : seq[m_pos]);
    chk("model_vel_index", int'(vel_index), m_vi);
    chk("model_step", int'(step), int'(m_step));
    chk("model_running", int'(running), int'(m_speed));
  end

  task automatic wait_run(input int lim, input string nm);
    int k = 0;
    while (!running && k < lim) begin tick(1); k++; end
    chk(nm, int'(running), 1);
  endtask

  task automatic align_then_exit(input string nm);
    for (int k = 0; k < AC; k++) begin
      tick(1);
      chk({nm, "_align_phase"}, int'(phase_state), 1);
    end
    tick(1);
    chk({nm, "_exit_phase"}, int'(phase_state), 3);
    chk({nm, "_exit_step"}, int'(step), 1);
    chk({nm, "_exit_vi"}, int'(vel_index), 1);
  endtask

  initial begin
    int ns, dbl, zeros, k;
    bit prev;
    tbl = '{32'd2, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd4};
    #1 rst_n = 1'b0;
    tick(2);
    chk("rst_phase", int'(phase_state), 0);
    chk("rst_vi", int'(vel_index), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_running", int'(running), 0);

    // Ramp 1->2->3 with T=5
    en = 1'b1; vel = 8'd3; rst_n = 1'b1;
    align_then_exit("start");
    tick(5);
    chk("ramp_phase_010", int'(phase_state), 2);
    chk("ramp_step", int'(step), 1);
    tick(5);
    chk("ramp_phase_110", int'(phase_state), 6);
    chk("ramp_vi2", int'(vel_index), 2);
    tick(10);
    chk("ramp_phase_101", int'(phase_state), 5);
    chk("ramp_vi3", int'(vel_index), 3);
    chk("ramp_running", int'(running), 1);

    // Mid-step period change: shrink below elapsed count
    t_fixed = 32'd20; tick(6);
    t_fixed = 32'd3;  tick(12);

    // Short periods 0 and 1 both give a 2-clock step
    for (int p = 0; p < 2; p++) begin
      t_fixed = 32'(p);
      tick(4);
      ns = 0; dbl = 0; prev = step;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (step) ns++;
        if (prev && step) dbl++;
        prev = step;
      end
      chk("short_step_count", ns, 10);
      chk("short_step_double", dbl, 0);
    end

    // Accelerate to 5, then decelerate to 2 (upper vel bits ignored)
    t_fixed = 32'd3; vel = 8'hF5;
    tick(1);
    wait_run(200, "accel_timeout");
    chk("accel_vi5", int'(vel_index), 5);
    vel = 8'hA2;
    tick(1);
    chk("decel_running_drop", int'(running), 0);
    zeros = 0; k = 0;
    while (!running && k < 200) begin
      tick(1); k++;
      if (phase_state == 3'b000) zeros++;
    end
    chk("decel_running", int'(running), 1);
    chk("decel_vi2", int'(vel_index), 2);
    chk("decel_no_off_phase", zeros, 0);

    // Stop in RUN via en, then full re-alignment
    en = 1'b0;
    tick(1);
    chk("stop_phase", int'(phase_state), 0);
    chk("stop_vi", int'(vel_index), 0);
    chk("stop_step", int'(step), 0);
    chk("stop_running", int'(running), 0);
    en = 1'b1;
    align_then_exit("reen");

    // Stop via vel=0 in RAMP on a cycle that would have stepped
    tick(2);
    vel = 8'd0;
    tick(1);
    chk("stop_ramp_step", int'(step), 0);
    chk("stop_ramp_phase", int'(phase_state), 0);
    chk("stop_ramp_vi", int'(vel_index), 0);

    // Table-driven periods up to index 7
    use_tbl = 1'b1; vel = 8'd7;
    tick(1);
    wait_run(600, "table_timeout");
    chk("table_vi7", int'(vel_index), 7);
    k = 0;
    while (!step && k < 50) begin tick(1); k++; end
    chk("table_step_seen", int'(step), 1);
    k = 0;
    do begin tick(1); k++; end while (!step && k < 50);
    chk("table_spacing", k, 4);

    // Asynchronous reset mid-run
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", int'(phase_state), 0);
    chk("async_rst_vi", int'(vel_index), 0);
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_running", int'(running), 0);
    tick(2);
    use_tbl = 1'b0; t_fixed = 32'd5; vel = 8'd3;
    rst_n = 1'b1;
    align_then_exit("after_rst");
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bldc_commutation_ctrl.md
# bldc_commutation_ctrl

Six-step commutation sequencer for the BLDC drive. Reads the enable and velocity fields published by `bldc_registers`, drives `vel_index` into `lookup_table`, and times each commutation step from the returned period `T_value`. Its `phase_state` output feeds back into `bldc_registers`. It performs rotor alignment, then ramps `vel_index` one index at a time from 1 up to the commanded speed, then holds steady run.

## Interface

Parameters:
- `ALIGN_CYCLES`, default 50000: clocks `phase_state` is held at 3'b001 during alignment (1 ms at 50 MHz).
- `RAMP_STEPS`, default 6: commutation steps spent at each `vel_index` before moving one index toward the target.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: asynchronous, active-low reset.
- `en`  in  1: motor enable, from `bldc_registers`.
- `vel`  in  8: commanded velocity. Only `vel[2:0]` is used, as the target index; upper bits are ignored.
- `T_value`  in  32: commutation period in clocks, from `lookup_table`, combinational on `vel_index`.
- `vel_index`  out  3: index driven to `lookup_table`.
- `phase_state`  out  3: commutation state, to `bldc_registers`.
- `step`  out  1: one-cycle pulse on every commutation.
- `running`  out  1: high only in RUN.

## Operation

- The target is `tgt = vel[2:0]`, sampled live every cycle.
- The stop condition is `en==0 || tgt==0`. It is checked in every state and has priority over all other transitions. It forces IDLE on the next edge.
- Six-step sequence, advanced one entry per step and wrapping after the last: 001, 011, 010, 110, 100, 101, then back to 001. 000 means off.
- State encoding: IDLE=0, ALIGN=1, RAMP=2, RUN=3.
- **IDLE**
  - Outputs: `phase_state`=000, `vel_index`=0, timer=0, step counter=0.
  - If the stop condition is false, go to ALIGN with `phase_state`=001.
- **ALIGN**
  - Hold `phase_state`=001 for exactly `ALIGN_CYCLES` clocks.
  - On the last of those clocks, go to RAMP and in the same edge:
    - set `phase_state`=011,
    - set `vel_index`=1,
    - assert `step`,
    - clear the timer and step counter.
- **Step timer** (active in RAMP and RUN)
  - `cnt` increments every clock.
  - A step fires when `cnt >= Teff-1`, where `Teff = max(T_value, 2)`. `T_value` of 0 or 1 is therefore treated as 2.
  - On a step: `cnt` resets to 0, `phase_state` advances one entry, `step` is high for that cycle.
  - `T_value` is compared live. A mid-step change to `T_value` shortens or lengthens the current step. If `cnt` is already past the new limit, the step fires on the next clock.
- **RAMP**
  - Each step increments the step counter.
  - When the counter reaches `RAMP_STEPS`, it resets, and on that same step edge `vel_index` moves by ±1 toward `tgt`.
  - When `vel_index==tgt` after an update, or on entry to RAMP if already equal, go to RUN.
- **RUN**
  - `running`=1 and steps continue at the same rate.
  - If `tgt != vel_index`, return to RAMP with the step counter cleared. The phase sequence and timer are undisturbed.
- Arithmetic:
  - `cnt` is 32-bit unsigned.
  - The step counter is wide enough for `RAMP_STEPS` and saturates rather than wrapping.
  - `vel_index` never wraps past 0 or 7.

## Timing

- All outputs are registered.
- Reset values: `phase_state`=000, `vel_index`=0, `step`=0, `running`=0, state IDLE.
- `step` and the new `phase_state` appear on the same edge.
- A `vel_index` change takes effect on the step edge. The new `T_value` governs the very next step.
- Minimum step length is 2 clocks.
- Stop-condition latency is 1 clock to `phase_state`=000 and `running`=0. A step that would coincide with stop is suppressed.
- Reset asserted mid-operation clears everything asynchronously. After release, the block restarts from IDLE, passes through ALIGN, and ramps again from index 1.
- If `en` is re-asserted in the cycle after a stop, the full ALIGN duration is repeated. There is no shortcut.

## Test plan

All scenarios use `ALIGN_CYCLES`=4 and `RAMP_STEPS`=2.
- **Reset:** hold `rst` low mid-run -> all outputs zero immediately. After release with `en`=1 and `vel`=3 -> `phase_state`=001 for exactly 4 clocks, then 011 with a `step` pulse and `vel_index`=1.
- **Ramp:** `en`=1, `vel`=3, bench `T_value`=5 -> steps every 5 clocks, `phase_state` walks 011,010,110,100,... `vel_index` goes 1→2→3 after 2 steps each, then `running`=1.
- **Short period:** `T_value`=0, then 1 -> steps every 2 clocks in both cases. No `step` pulse ever lasts more than one cycle.
- **Decel:** in RUN at index 5, write `vel`=2 -> `running` drops next clock. `vel_index` goes 5→4→3→2, 2 steps each, then back to RUN. The phase sequence stays continuous with no 000.
- **Stop:** `en`=0 or `vel`=0 in RAMP or RUN -> next clock `phase_state`=000, `vel_index`=0, no `step`. Re-enable -> a full 4-cycle ALIGN is repeated.
- **Integration:** with the real `lookup_table` and `bldc_registers`, write `vel`=7 -> `phase_state` readback cycles through the six codes, and the step spacing equals `lookup_table` T for each index reached.
